// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous updates.
// Ports: data_in/dp_in/load in, live masks in, seg/dp/dig_sel/frame_done out.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic [4*DIGITS-1:0] pend_data;
  logic [4*DIGITS-1:0] disp_data;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   disp_dp;
  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       blink_cnt;
  logic                blink_off;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   dig_q;

  logic                wrap;
  logic                fd;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                dark;
  logic                run;
  logic [DIGITS-1:0]   lz_vec;
  logic [DIGITS-1:0]   dig_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign wrap = (div_cnt == DLAST);
  assign fd   = wrap && (idx == ILAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      if (wrap) begin
        div_cnt <= '0;
        idx     <= (idx == ILAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fd) begin
        if (blink_cnt == BLAST) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // A load landing on the frame boundary bypasses pending so it
  // is not delayed a whole extra frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else begin
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (fd) begin
        disp_data <= load ? data_in : pend_data;
        disp_dp   <= load ? dp_in : pend_dp;
      end
    end
  end

  // lz_vec[k]: digits k..top are all zero with no dp; digit 0 exempt.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    dig_next = '0;
    lz_vec   = '0;
    run      = lz_en;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run && (disp_data[4*k +: 4] == 4'h0) && !disp_dp[k];
      lz_vec[k] = run && (k > 0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib     = disp_data[4*k +: 4];
        cur_dp      = disp_dp[k];
        dig_next[k] = 1'b1;
      end
    end
    dark = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        dark = blank_mask[k] || (blink_mask[k] && blink_off) || lz_vec[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h00;
      dp_q  <= 1'b0;
      dig_q <= '0;
    end else begin
      dig_q <= dig_next;
      seg_q <= dark ? 7'h00 : decode(cur_nib);
      dp_q  <= !dark && cur_dp;
    end
  end

  assign seg_out    = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp_out     = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign dig_sel    = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;
  assign frame_done = fd;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: active-high, active-low and 1-digit instances.
// Table-driven frame checks plus load, blink and reset sequences.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;

  logic [6:0]  seg_a, seg_b, seg_c;
  logic        dp_a, dp_b, dp_c;
  logic [3:0]  dig_a, dig_b;
  logic [0:0]  dig_c;
  logic        fd_a, fd_b, fd_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2))
  u_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
    .load(load), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .lz_en(lz_en), .seg_out(seg_a), .dp_out(dp_a), .dig_sel(dig_a),
    .frame_done(fd_a)
  );

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
  u_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
    .load(load), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .lz_en(lz_en), .seg_out(seg_b), .dp_out(dp_b), .dig_sel(dig_b),
    .frame_done(fd_b)
  );

  seg7_scan_driver #(.DIGITS(1), .CLK_DIV(3), .BLINK_FRAMES(1))
  u_c (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[3:0]), .dp_in(dp_in[0]),
    .load(load), .blank_mask(blank_mask[0]), .blink_mask(blink_mask[0]),
    .lz_en(lz_en), .seg_out(seg_c), .dp_out(dp_c), .dig_sel(dig_c),
    .frame_done(fd_c)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  blank;
    logic [27:0] seg;
    logic [3:0]  edp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    tick();
    while (!fd_a && n < 100) begin
      tick();
      n++;
    end
    chk("frame_done_timeout", {31'd0, fd_a}, 32'd1);
  endtask

  // Called one sample after frame_done; covers the next full frame.
  task automatic check_frame(input logic [27:0] seg, input logic [3:0] dp,
                             input string nm);
    logic [3:0] oh;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        oh = 4'b0001 << k;
        chk({nm, "_dig"}, {28'd0, dig_a}, {28'd0, oh});
        chk({nm, "_seg"}, {25'd0, seg_a}, {25'd0, seg[7*k +: 7]});
        chk({nm, "_dp"}, {31'd0, dp_a}, {31'd0, dp[k]});
        chk({nm, "_fd"}, {31'd0, fd_a}, {31'd0, (k == 3 && c == 2)});
        chk({nm, "_dig_lo"}, {28'd0, dig_b}, {28'd0, ~oh});
        chk({nm, "_seg_lo"}, {25'd0, seg_b}, {25'd0, ~seg[7*k +: 7]});
        chk({nm, "_dp_lo"}, {31'd0, dp_b}, {31'd0, ~dp[k]});
      end
    end
  endtask

  initial begin
    int nfd;
    vecs[0] = '{16'h1234, 4'h0, 1'b0, 4'h0,
                {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0};
    vecs[1] = '{16'h00A0, 4'h0, 1'b1, 4'h0,
                {7'h00, 7'h00, 7'h77, 7'h3F}, 4'h0};
    vecs[2] = '{16'h0000, 4'h0, 1'b1, 4'h0,
                {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0};
    vecs[3] = '{16'h0000, 4'h4, 1'b1, 4'h0,
                {7'h00, 7'h3F, 7'h3F, 7'h3F}, 4'h4};
    vecs[4] = '{16'hFEDC, 4'h0, 1'b0, 4'h2,
                {7'h71, 7'h79, 7'h00, 7'h39}, 4'h0};
    vecs[5] = '{16'h5678, 4'h0, 1'b0, 4'h0,
                {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'h0};
    vecs[6] = '{16'h9AB0, 4'hF, 1'b0, 4'h8,
                {7'h00, 7'h77, 7'h7C, 7'h3F}, 4'h7};

    #1;
    chk("rst_seg", {25'd0, seg_a}, 32'h0);
    chk("rst_dig", {28'd0, dig_a}, 32'h0);
    chk("rst_dp", {31'd0, dp_a}, 32'h0);
    chk("rst_fd", {31'd0, fd_a}, 32'h0);
    chk("rst_seg_lo", {25'd0, seg_b}, 32'h7F);
    chk("rst_dig_lo", {28'd0, dig_b}, 32'hF);
    chk("rst_dp_lo", {31'd0, dp_b}, 32'h1);
    chk("rst_dig_1", {31'd0, dig_c}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    nfd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("one_digit_sel", {31'd0, dig_c}, 32'h1);
      if (fd_c) nfd++;
    end
    chk("one_digit_fd_count", nfd, 32'd4);

    for (int i = 0; i < 7; i++) begin
      data_in    = vecs[i].data;
      dp_in      = vecs[i].dp;
      lz_en      = vecs[i].lz;
      blank_mask = vecs[i].blank;
      load       = 1'b1;
      tick();
      load = 1'b0;
      wait_fd();
      tick();
      check_frame(vecs[i].seg, vecs[i].edp, $sformatf("vec%0d", i));
    end

    // Two loads inside one frame; display holds until frame_done.
    wait_fd();
    blank_mask = 4'h0;
    lz_en      = 1'b0;
    dp_in      = 4'h0;
    for (int i = 0; i < 9; i++) tick();
    data_in = 16'h1111;
    load    = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    data_in = 16'h2222;
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("hold_dig", {28'd0, dig_a}, 32'h8);
    chk("hold_seg", {25'd0, seg_a}, 32'h6F);
    chk("hold_dp", {31'd0, dp_a}, 32'h1);
    wait_fd();
    tick();
    check_frame({4{7'h5B}}, 4'h0, "last_load");

    // Load on the frame_done cycle goes straight to display.
    wait_fd();
    data_in = 16'h3333;
    load    = 1'b1;
    tick();
    load = 1'b0;
    check_frame({4{7'h4F}}, 4'h0, "coincident");

    // Asynchronous reset in the middle of digit 2's slot.
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_dig", {28'd0, dig_a}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", {25'd0, seg_a}, 32'h0);
    chk("arst_dig", {28'd0, dig_a}, 32'h0);
    chk("arst_dp", {31'd0, dp_a}, 32'h0);
    chk("arst_fd", {31'd0, fd_a}, 32'h0);
    chk("arst_seg_lo", {25'd0, seg_b}, 32'h7F);
    chk("arst_dig_lo", {28'd0, dig_b}, 32'hF);
    tick();
    tick();
    rst_n      = 1'b1;
    data_in    = 16'h3333;
    blink_mask = 4'h2;
    load       = 1'b1;
    tick();
    load = 1'b0;
    chk("restart_dig", {28'd0, dig_a}, 32'h1);
    chk("restart_seg", {25'd0, seg_a}, 32'h3F);

    // Blink: 2 frames on, 2 off, digit 1 only.
    wait_fd();
    tick();
    check_frame({4{7'h4F}}, 4'h0, "blink_on1");
    check_frame({7'h4F, 7'h4F, 7'h00, 7'h4F}, 4'h0, "blink_off1");
    check_frame({7'h4F, 7'h4F, 7'h00, 7'h4F}, 4'h0, "blink_off2");
    check_frame({4{7'h4F}}, 4'h0, "blink_on2");
    check_frame({4{7'h4F}}, 4'h0, "blink_on3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display.
- Latches a packed vector of 4-bit hex/BCD nibbles and decodes each to segments a..g.
- Scans the digits one at a time, one-hot, at a programmable rate.
- Adds leading-zero blanking, per-digit blanking, per-digit blink and tear-free frame-synchronous updates.
- Sits between the game/score logic and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- CLK_DIV, 1000, clk cycles each digit stays selected; must be >= 2.
- BLINK_FRAMES, 64, complete scan frames per blink half-period; must be >= 1.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_out and dp_out at the pins.
- DIG_ACTIVE_LOW, 0, 1 inverts dig_sel at the pins.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  4*DIGITS  nibble k = data_in[4k+3:4k] = digit k; digit 0 = least significant / rightmost.
- dp_in  in  DIGITS  decimal point request per digit.
- load  in  1  capture data_in and dp_in into the pending register.
- blank_mask  in  DIGITS  1 = force digit dark; sampled live.
- blink_mask  in  DIGITS  1 = digit blinks; sampled live.
- lz_en  in  1  enable leading-zero blanking; sampled live.
- seg_out  out  7  segments; bit0 = a … bit6 = g.
- dp_out  out  1  decimal point segment.
- dig_sel  out  DIGITS  one-hot digit enable.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - pending and display registers are 0.
  - Divider count, digit index and blink-frame count are 0; blink phase = 0 (on).
  - seg_out = 0, dp_out = 0, dig_sel = 0, frame_done = 0, all at logical level before inversion.
- Reset mid-frame aborts the scan; the first slot after release is digit 0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - At wrap, digit index advances 0→1→…→DIGITS-1→0.
  - frame_done = 1 for the cycle in which the divider wraps while index = DIGITS-1.
- Outputs are registered:
  - dig_sel, seg_out and dp_out change together, one cycle after the index changes.
  - Each digit stays lit for exactly CLK_DIV cycles.
  - dig_sel is never two-hot, and is never one-hot with stale segment data.
- Load and display update:
  - load = 1 copies data_in and dp_in into pending on the next edge.
  - pending is copied into display only on the frame_done cycle.
  - If load and frame_done coincide, the new data_in goes straight into display.
  - Repeated loads within a frame: the last one wins.
- Decode (logical, active-high; a lit segment = 1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Values shown as {g..a} hex.
- Digit k is dark (seg_out = 0, dp_out = 0, dig_sel still asserted) when any of:
  - blank_mask[k] = 1;
  - blink_mask[k] = 1 and blink phase = off;
  - lz_en = 1, k > 0, and every display nibble from k up to DIGITS-1 is 0 with its dp bit 0.
- Digit 0 is never blanked by leading-zero blanking.
- Blink:
  - The frame counter counts frame_done pulses 0..BLINK_FRAMES-1.
  - At wrap, the phase toggles.
  - Phase changes only at frame boundaries.
- Pin polarity: inversion per SEG_ACTIVE_LOW / DIG_ACTIVE_LOW is applied after the registers; reset levels are also inverted.
- DIGITS = 1: dig_sel is constant 1 after reset and frame_done pulses every CLK_DIV cycles.

Test Plan:
- Reset release, DIGITS=4, CLK_DIV=4, load 0x1234 → no output until load; after the first frame_done, dig_sel = 0001 (seg 4F "3"… wait, digit 0 = nibble 4 → 66), then 0010 (4F), 0100 (5B), 1000 (06); each slot lasts 4 cycles; frame_done period is 16.
- Load 0x00A0 with lz_en=1 → digits 3 and 2 dark, digit 1 = 77, digit 0 = 3F. Load 0x0000 → only digit 0 lit, showing 3F.
- Load during slot 2, then a second load in slot 3 → display unchanged until frame_done, then shows the second value; load coincident with frame_done → that value shown in the next frame.
- BLINK_FRAMES=2, blink_mask=0010 → digit 1 lit 2 frames, dark 2 frames, repeating; other digits steady; phase never changes mid-frame.
- SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 → reset gives seg_out=7F, dig_sel=1111; digit showing 8 drives seg_out=00; dp_in bit set drives dp_out=0.
- Assert rst_n=0 mid-slot 2 → all outputs go to reset levels immediately without a clock; after release, scan restarts at digit 0 with blank display data.
